// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, FSM state
// encodings and the datapath mux-select encodings it drives.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select and enable, stalling on mem_ready_i.
//
//  state     | meaning
//  ----------+--------------------------------------------------
//  FETCH     | read instruction at PC, PC+4 -> PC on mem_ready
//  DECODE    | read regs, precompute branch target, dispatch
//  MEM_ADDR  | base + sign-ext offset for lw/sw
//  MEM_READ  | data read at ALUOut, wait for mem_ready
//  MEM_WB    | MDR -> rt
//  MEM_WRITE | store B at ALUOut, wait for mem_ready
//  EXECUTE   | R-type ALU operation
//  R_WB      | ALUOut -> rd
//  BRANCH    | compare A-B, take branch if zero
//  JUMP      | load jump target into PC
//  ADDI_EX   | A + sign-ext imm
//  ADDI_WB   | ALUOut -> rt
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode_i == OP_SW) state_d = S_MEM_WRITE;
                else                   state_d = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXECUTE: state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_i directly so FETCH's read strobe cannot
    // escape while the state register is being held in reset.
    always_comb begin
        pc_en_o      = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REG;
        alu_op_o     = ALUOP_ADD;
        pc_source_o  = PCSRC_ALU;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        if (!rst_i) begin
            illegal_o = illegal_q;
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = SRCB_FOUR;
                    ir_write_o  = mem_ready_i;
                    pc_en_o     = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = SRCB_IMM_SH;
                    case (opcode_i)
                        OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: instr_done_o = 1'b0;
                        default:                                    instr_done_o = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                end
                S_MEM_READ: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg_o = 1'b1;
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write_o  = 1'b1;
                    iord_o       = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                S_EXECUTE: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    reg_dst_o    = 1'b1;
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o  = 1'b1;
                    alu_op_o     = ALUOP_SUB;
                    pc_source_o  = PCSRC_ALUOUT;
                    pc_en_o      = zero_i;
                    instr_done_o = 1'b1;
                end
                S_JUMP: begin
                    pc_source_o  = PCSRC_JUMP;
                    pc_en_o      = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                end
                S_ADDI_WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver pushes the expected
// output vector for every cycle it drives, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
    localparam int EX = 6, RWB = 7, BR = 8, JP = 9, AEX = 10, AWB = 11;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;

    mips_multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero),
        .mem_ready_i(mem_ready), .pc_en_o(pc_en), .iord_o(iord),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .pc_source_o(pc_source), .instr_done_o(instr_done), .illegal_o(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    outs_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    logic  ill_model = 1'b0;
    string cur_test = "reset";

    function automatic logic bad_op(input logic [5:0] op);
        return !(op == 6'h00 || op == 6'h23 || op == 6'h2B ||
                 op == 6'h04 || op == 6'h02 || op == 6'h08);
    endfunction

    // Expected outputs per state, written out from the control table.
    function automatic outs_t exp_out(input int st, input logic mr, input logic z,
                                      input logic ill, input logic r, input logic bad);
        outs_t o;
        o = '0;
        if (r) return o;
        o.illegal = ill;
        case (st)
            F:   begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
            D:   begin o.alu_src_b = 2'b11; o.instr_done = bad; end
            MA:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            MR:  begin o.mem_read = 1; o.iord = 1; end
            MWB: begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
            MW:  begin o.mem_write = 1; o.iord = 1; o.instr_done = mr; end
            EX:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            RWB: begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
            BR:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01;
                       o.pc_en = z; o.instr_done = 1; end
            JP:  begin o.pc_source = 2'b10; o.pc_en = 1; o.instr_done = 1; end
            AEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            AWB: begin o.reg_write = 1; o.instr_done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic step(input int st, input logic [5:0] op, input logic mr,
                        input logic z, input logic r);
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(exp_out(st, mr, z, ill_model, r, bad_op(op)));
        name_q.push_back(cur_test);
        if (r) ill_model = 1'b0;
        else if (st == D && bad_op(op)) ill_model = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        outs_t act, e;
        string nm;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                        reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s cyc=%0d outputs actual=%b required=%b", nm, cyc, act, e);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        step(F, 6'h00, 1, 0, 1);
        step(F, 6'h00, 1, 0, 1);

        cur_test = "r_type";
        step(F, 6'h00, 1, 0, 0); step(D, 6'h00, 1, 0, 0);
        step(EX, 6'h00, 1, 0, 0); step(RWB, 6'h00, 1, 0, 0);

        cur_test = "lw_stall";
        step(F, 6'h23, 1, 0, 0); step(D, 6'h23, 1, 0, 0); step(MA, 6'h23, 1, 0, 0);
        step(MR, 6'h23, 0, 0, 0); step(MR, 6'h23, 0, 0, 0); step(MR, 6'h23, 1, 0, 0);
        step(MWB, 6'h23, 1, 0, 0);

        cur_test = "beq_taken";
        step(F, 6'h04, 1, 1, 0); step(D, 6'h04, 1, 1, 0); step(BR, 6'h04, 1, 1, 0);
        cur_test = "beq_not_taken";
        step(F, 6'h04, 1, 0, 0); step(D, 6'h04, 1, 0, 0); step(BR, 6'h04, 1, 0, 0);

        cur_test = "jump";
        step(F, 6'h02, 1, 0, 0); step(D, 6'h02, 1, 0, 0); step(JP, 6'h02, 1, 0, 0);

        cur_test = "sw_stalls";
        step(F, 6'h2B, 0, 0, 0); step(F, 6'h2B, 1, 0, 0); step(D, 6'h2B, 1, 0, 0);
        step(MA, 6'h2B, 1, 0, 0); step(MW, 6'h2B, 0, 0, 0); step(MW, 6'h2B, 1, 0, 0);

        cur_test = "addi";
        step(F, 6'h08, 1, 0, 0); step(D, 6'h08, 1, 0, 0);
        step(AEX, 6'h08, 1, 0, 0); step(AWB, 6'h08, 1, 0, 0);

        cur_test = "illegal_op";
        step(F, 6'h3F, 1, 0, 0); step(D, 6'h3F, 1, 0, 0);

        cur_test = "illegal_sticky";
        step(F, 6'h00, 1, 0, 0); step(D, 6'h00, 1, 0, 0);
        step(EX, 6'h00, 1, 0, 0); step(RWB, 6'h00, 1, 0, 0);

        cur_test = "rst_mid_lw";
        step(F, 6'h23, 1, 0, 0); step(D, 6'h23, 1, 0, 0); step(MA, 6'h23, 1, 0, 0);
        step(MR, 6'h23, 0, 0, 0);
        step(MR, 6'h23, 1, 0, 1); step(MR, 6'h23, 1, 0, 1);

        cur_test = "after_rst";
        step(F, 6'h02, 1, 0, 0); step(D, 6'h02, 1, 0, 0); step(JP, 6'h02, 1, 0, 0);

        #20;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
